// File: rtl/uart_rx_unit.sv
// 16x-oversampled UART receiver: two-flop rx synchronizer, free-running baud tick and a
// frame FSM that reports exactly one registered outcome pulse per completed frame.
module uart_rx_unit #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 163,
  parameter int DVSR_BIT   = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            full,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun_err
);

  // s is 5 bits so that 1.5 and 2 stop bits (24/32 ticks) still fit.
  localparam int SW = 5;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0]       S_MID    = SW'(7);
  localparam logic [SW-1:0]       S_BIT    = SW'(15);
  localparam logic [SW-1:0]       S_STOP   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0]       N_LAST   = NW'(DBIT - 1);
  localparam logic [DVSR_BIT-1:0] CNT_LAST = DVSR_BIT'(DVSR - 1);
  localparam logic                P_INIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BRK   = 3'd5
  } state_t;

  function automatic logic par_acc(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  logic                sync1_q, rx_s_q;
  logic [DVSR_BIT-1:0] cnt_q, cnt_d;
  logic                s_tick;
  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [DBIT-1:0]     b_q, b_d;
  logic                p_q, p_d;
  logic                perr_q, perr_d;
  logic [DBIT-1:0]     dout_q, dout_d;
  logic                done_q, done_d;
  logic                ferr_q, ferr_d;
  logic                parerr_q, parerr_d;
  logic                ovr_q, ovr_d;

  // Two-flop synchronizer; the line idles high so both flops reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Baud tick generator; free-running, never realigned to the start edge.
  always_comb begin
    s_tick = (cnt_q == CNT_LAST);
    if (s_tick) begin
      cnt_d = {DVSR_BIT{1'b0}};
    end else begin
      cnt_d = cnt_q + DVSR_BIT'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {DVSR_BIT{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Frame FSM next-state and outcome decode.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    p_d      = p_q;
    perr_d   = perr_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    parerr_d = 1'b0;
    ovr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          s_d     = {SW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              s_d     = {SW{1'b0}};
              n_d     = {NW{1'b0}};
              p_d     = P_INIT;
              perr_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            p_d = par_acc(p_q, rx_s_q);
            s_d = {SW{1'b0}};
            if (n_q == N_LAST) begin
              state_d = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PAR: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            perr_d  = par_acc(p_q, rx_s_q);
            s_d     = {SW{1'b0}};
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = ST_PAR;
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            s_d     = {SW{1'b0}};
            state_d = ST_IDLE;
            // Outcome priority: framing, then parity, then overrun, then accept.
            if (!rx_s_q) begin
              ferr_d  = 1'b1;
              state_d = ST_BRK;
            end else if (perr_q) begin
              parerr_d = 1'b1;
            end else if (full) begin
              ovr_d = 1'b1;
            end else begin
              dout_d = b_q;
              done_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BRK: begin
        if (s_tick && rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BRK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      s_q      <= {SW{1'b0}};
      n_q      <= {NW{1'b0}};
      b_q      <= {DBIT{1'b0}};
      p_q      <= 1'b0;
      perr_q   <= 1'b0;
      dout_q   <= {DBIT{1'b0}};
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      parerr_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      b_q      <= b_d;
      p_q      <= p_d;
      perr_q   <= perr_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      parerr_q <= parerr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = parerr_q;
  assign overrun_err  = ovr_q;

endmodule
